dmem_cache: RTL

Parametrised successor of the CPU data-memory stage. Decodes word-address MMIO (UART data/status) and serves all other addresses from a direct-mapped, write-back, write-allocate cache. Multi-word lines are refilled from and written back to a DRAM-side beat port. Sits between the decode/exec stage and writeback. Drives stall on misses so the core pipeline freezes.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_line_store.sv | 53 +++++
 rtl/dmem_cache.sv | 138 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and address-split helpers for the data-memory stage.
package dmem_pkg;

   typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

   localparam int MMIO_UART_DATA = 0;
   localparam int MMIO_UART_STAT = 1;

   function automatic int tag_len(int addr_len, int index_len, int offset_len);
      return addr_len - index_len - offset_len;
   endfunction

   function automatic int tag_lsb(int index_len, int offset_len);
      return index_len + offset_len;
   endfunction

endpackage

// File: rtl/dmem_line_store.sv
// Cache storage: tag/data arrays plus resettable valid and dirty vectors.
module dmem_line_store #(
   parameter int INDEX_LEN  = 8,
   parameter int OFFSET_LEN = 2,
   parameter int TAG_LEN    = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_LEN-1:0]  index,
   input  logic [OFFSET_LEN-1:0] offset,
   input  logic                  word_we,
   input  logic [31:0]           word_wdata,
   output logic [31:0]           word_rdata,
   input  logic                  set_dirty,
   input  logic                  fill_done,
   input  logic [TAG_LEN-1:0]    fill_tag,
   output logic [TAG_LEN-1:0]    line_tag,
   output logic                  line_valid,
   output logic                  line_dirty
);

   localparam int LINES = 1 << INDEX_LEN;
   localparam int WORDS = 1 << (INDEX_LEN + OFFSET_LEN);

   logic [TAG_LEN-1:0] tag_array  [LINES];
   logic [31:0]        data_array [WORDS];
   logic [LINES-1:0]   valid;
   logic [LINES-1:0]   dirty;

   // NOTE: arrays carry no reset so they map onto RAM; valid bits alone gate their use.
   always_ff @(posedge clk) begin
      if (word_we)   data_array[{index, offset}] <= word_wdata;
      if (fill_done) tag_array[index]            <= fill_tag;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= '0;
         dirty <= '0;
      end else if (fill_done) begin
         valid[index] <= 1'b1;
         dirty[index] <= 1'b0;
      end else if (set_dirty) begin
         dirty[index] <= 1'b1;
      end
   end

   assign word_rdata = data_array[{index, offset}];
   assign line_tag   = tag_array[index];
   assign line_valid = valid[index];
   assign line_dirty = dirty[index];

endmodule

// File: rtl/dmem_cache.sv
// Data-memory stage: UART MMIO decode plus a direct-mapped write-back cache
// with a beat-serial DRAM refill/write-back port.
module dmem_cache
   import dmem_pkg::*;
#(
   parameter int ADDR_LEN   = 25,
   parameter int INDEX_LEN  = 8,
   parameter int OFFSET_LEN = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_LEN-1:0] dec_daddr,
   input  logic                dec_mre,
   input  logic                dec_mwe,
   input  logic [31:0]         op2,
   output logic                stall,
   output logic [31:0]         wb_memdata,
   input  logic [7:0]          rx_data,
   input  logic                rx_empty,
   output logic                rx_rd_en,
   input  logic                tx_full,
   output logic                tx_wr_en,
   output logic [7:0]          tx_data,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_LEN-1:0] mem_addr,
   output logic [31:0]         mem_wdata,
   input  logic [31:0]         mem_rdata,
   input  logic                mem_ready
);

   localparam int TAG_LEN = tag_len(ADDR_LEN, INDEX_LEN, OFFSET_LEN);
   localparam int TAG_LSB = tag_lsb(INDEX_LEN, OFFSET_LEN);
   localparam logic [OFFSET_LEN-1:0] LAST_BEAT = '1;

   state_t                state;
   logic [OFFSET_LEN-1:0] cnt;
   logic [TAG_LEN-1:0]    req_tag, line_tag;
   logic [INDEX_LEN-1:0]  req_index;
   logic [OFFSET_LEN-1:0] req_offset;
   logic [31:0]           word_rdata, mmio_rdata;
   logic                  req, is_load, is_store, is_mmio, is_uart_data;
   logic                  idle, hit, cached_req, miss, store_hit, last_beat;
   logic                  line_valid, line_dirty;

   assign req_tag    = dec_daddr[ADDR_LEN-1:TAG_LSB];
   assign req_index  = dec_daddr[TAG_LSB-1:OFFSET_LEN];
   assign req_offset = dec_daddr[OFFSET_LEN-1:0];

   assign req          = dec_mre | dec_mwe;
   assign is_store     = dec_mwe;
   assign is_load      = dec_mre & ~dec_mwe;
   assign is_mmio      = (dec_daddr[ADDR_LEN-1:1] == '0);
   assign is_uart_data = is_mmio & (dec_daddr[0] == 1'(MMIO_UART_DATA));

   assign idle       = (state == IDLE);
   assign hit        = line_valid & (line_tag == req_tag);
   assign cached_req = idle & req & ~is_mmio;
   assign miss       = cached_req & ~hit;
   assign store_hit  = cached_req & hit & is_store;
   assign last_beat  = (cnt == LAST_BEAT);

   assign stall    = rst & (~idle | miss);
   assign rx_rd_en = rst & idle & is_load & is_uart_data & ~rx_empty;
   assign tx_wr_en = rst & idle & is_store & is_uart_data & ~tx_full;
   assign tx_data  = op2[7:0];

   assign mem_req   = (state != IDLE);
   assign mem_we    = (state == WB);
   assign mem_addr  = {(state == WB) ? line_tag : req_tag, req_index, cnt};
   assign mem_wdata = word_rdata;

   // NOTE: the default assignment keeps this combinational block latch-free.
   always_comb begin
      mmio_rdata = '0;
      if (is_uart_data) begin
         if (!rx_empty) mmio_rdata = {24'b0, rx_data};
      end else if (dec_daddr[0] == 1'(MMIO_UART_STAT)) begin
         mmio_rdata = {30'b0, ~tx_full, ~rx_empty};
      end
   end

   // NOTE: all state updates are non-blocking so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         wb_memdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (is_load && is_mmio) begin
                  wb_memdata <= mmio_rdata;
               end else if (cached_req && hit && is_load) begin
                  wb_memdata <= word_rdata;
               end else if (miss) begin
                  cnt   <= '0;
                  state <= (line_valid && line_dirty) ? WB : FILL;
               end
            end
            WB: begin
               if (mem_ready) begin
                  cnt <= cnt + 1'b1;
                  if (last_beat) state <= FILL;
               end
            end
            FILL: begin
               if (mem_ready) begin
                  cnt <= cnt + 1'b1;
                  if (last_beat) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   dmem_line_store #(
      .INDEX_LEN (INDEX_LEN),
      .OFFSET_LEN(OFFSET_LEN),
      .TAG_LEN   (TAG_LEN)
   ) u_line_store (
      .clk       (clk),
      .rst       (rst),
      .index     (req_index),
      .offset    (idle ? req_offset : cnt),
      .word_we   (store_hit | ((state == FILL) & mem_ready)),
      .word_wdata((state == FILL) ? mem_rdata : op2),
      .word_rdata(word_rdata),
      .set_dirty (store_hit),
      .fill_done ((state == FILL) & mem_ready & last_beat),
      .fill_tag  (req_tag),
      .line_tag  (line_tag),
      .line_valid(line_valid),
      .line_dirty(line_dirty)
   );

endmodule
